// File: rtl/ex_mem_skid_latch.sv
// ex_mem_skid_latch: EX/MEM 2-entry skid latch with valid/ready handshake; define EXMEM_ZERO_SQUASH_EN to drop RegWrite for $0
module ex_mem_skid_latch #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [REG_W-1:0]  in_wreg,
    input  logic [1:0]        in_wb_ctl,
    input  logic [2:0]        in_m_ctl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_wdata,
    output logic [REG_W-1:0]  out_wreg,
    output logic [1:0]        out_wb_ctl,
    output logic [2:0]        out_m_ctl
);
    localparam int EW = 2 * DATA_W + REG_W + 5;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'(DEPTH)} state_t;
    state_t state, state_nx;
    logic [EW-1:0] e0, e1, din;
    logic [1:0] wb_in, wb0;
    logic [2:0] m0;
    logic push, pop, ld0_in, ld0_e1, ld1;
    assign in_ready  = state != FULL;
    assign out_valid = state != EMPTY;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
`ifdef EXMEM_ZERO_SQUASH_EN
    assign wb_in = {in_wb_ctl[1] & (in_wreg != '0), in_wb_ctl[0]};
`else
    assign wb_in = in_wb_ctl;
`endif
    assign din = {in_alu_result, in_wdata, in_wreg, wb_in, in_m_ctl};
    assign {out_alu_result, out_wdata, out_wreg, wb0, m0} = e0;
    assign out_wb_ctl = out_valid ? wb0 : 2'b00;
    assign out_m_ctl  = out_valid ? m0 : 3'b000;
    // occupancy state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= EMPTY;
        else state <= state_nx;
    end
    // next occupancy and entry load selects; flush overrides any push or pop
    always_comb begin
        state_nx = state;
        ld0_in   = 1'b0;
        ld0_e1   = 1'b0;
        ld1      = 1'b0;
        if (flush) state_nx = EMPTY;
        else
            case (state)
                EMPTY: begin
                    ld0_in   = push;
                    state_nx = push ? ONE : EMPTY;
                end
                ONE: begin
                    ld0_in   = push & pop;
                    ld1      = push & ~pop;
                    state_nx = push ? (pop ? ONE : FULL) : (pop ? EMPTY : ONE);
                end
                FULL: begin
                    ld0_e1   = pop;
                    state_nx = pop ? ONE : FULL;
                end
                default: state_nx = EMPTY;
            endcase
    end
    // head and skid entry storage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e0 <= '0;
            e1 <= '0;
        end else begin
            if (ld0_in) e0 <= din;
            else if (ld0_e1) e0 <= e1;
            if (ld1) e1 <= din;
        end
    end
endmodule

// File: tb/tb_ex_mem_skid_latch.sv
// tb_ex_mem_skid_latch: scoreboard bench with directed and random traffic for ex_mem_skid_latch
module tb_ex_mem_skid_latch;
    localparam int DW = 32;
    localparam int RW = 5;
    typedef struct packed {
        logic [DW-1:0] alu;
        logic [DW-1:0] wd;
        logic [RW-1:0] wreg;
        logic [1:0]    wb;
        logic [2:0]    m;
    } word_t;
    logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic in_ready, out_valid;
    logic [DW-1:0] in_alu_result = '0, in_wdata = '0, out_alu_result, out_wdata;
    logic [RW-1:0] in_wreg = '0, out_wreg;
    logic [1:0] in_wb_ctl = '0, out_wb_ctl;
    logic [2:0] in_m_ctl = '0, out_m_ctl;
    word_t sbq[$];
    int errors = 0, checks = 0;
    bit mon_en = 0;
    always #5 clk = ~clk;
    ex_mem_skid_latch dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_result(in_alu_result), .in_wdata(in_wdata), .in_wreg(in_wreg),
        .in_wb_ctl(in_wb_ctl), .in_m_ctl(in_m_ctl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_result(out_alu_result), .out_wdata(out_wdata), .out_wreg(out_wreg),
        .out_wb_ctl(out_wb_ctl), .out_m_ctl(out_m_ctl)
    );
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic word_t model_word(input logic [DW-1:0] alu, input logic [DW-1:0] wd,
                                         input logic [RW-1:0] wr, input logic [1:0] wb, input logic [2:0] m);
        word_t w;
        w = '{alu: alu, wd: wd, wreg: wr, wb: wb, m: m};
`ifdef EXMEM_ZERO_SQUASH_EN
        if (wr == 0) w.wb[1] = 1'b0;
`endif
        return w;
    endfunction
    // monitor: compare DUT head against scoreboard mid-cycle, retire on handshake
    always @(negedge clk) begin
        if (mon_en) begin
            check("in_ready", 64'(in_ready), 64'(sbq.size() < 2));
            check("out_valid", 64'(out_valid), 64'(sbq.size() != 0));
            if (sbq.size() != 0) begin
                check("out_alu_result", 64'(out_alu_result), 64'(sbq[0].alu));
                check("out_wdata", 64'(out_wdata), 64'(sbq[0].wd));
                check("out_wreg", 64'(out_wreg), 64'(sbq[0].wreg));
                check("out_wb_ctl", 64'(out_wb_ctl), 64'(sbq[0].wb));
                check("out_m_ctl", 64'(out_m_ctl), 64'(sbq[0].m));
                if (out_ready) void'(sbq.pop_front());
            end else begin
                check("idle_wb_ctl", 64'(out_wb_ctl), 64'd0);
                check("idle_m_ctl", 64'(out_m_ctl), 64'd0);
            end
        end
    end
    // one clock of stimulus; called just after a rising edge
    task automatic cyc(input bit v, input logic [DW-1:0] alu, input logic [DW-1:0] wd,
                       input logic [RW-1:0] wr, input logic [1:0] wb, input logic [2:0] m,
                       input bit ordy, input bit fl, input bit rs);
        bit acc;
        word_t w;
        in_valid = v; in_alu_result = alu; in_wdata = wd; in_wreg = wr;
        in_wb_ctl = wb; in_m_ctl = m; out_ready = ordy; flush = fl; rst_n = rs;
        w = model_word(alu, wd, wr, wb, m);
        @(negedge clk);
        acc = v && in_ready && !fl && rs;
        @(posedge clk);
        #1;
        if (fl || !rs) sbq.delete();
        else if (acc) sbq.push_back(w);
    endtask
    initial begin
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_wreg", 64'(out_wreg), 64'd0);
        check("rst_out_wb_ctl", 64'(out_wb_ctl), 64'd0);
        check("rst_out_m_ctl", 64'(out_m_ctl), 64'd0);
        check("rst_out_alu", 64'(out_alu_result), 64'd0);
        rst_n = 1;
        mon_en = 1;
        cyc(1, 32'h10, 32'hA5A5, 5'h15, 2'b10, 3'b000, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
        cyc(1, 32'h100, 32'h1, 5'h10, 2'b11, 3'b010, 0, 0, 1);
        cyc(1, 32'h200, 32'h2, 5'h0B, 2'b10, 3'b001, 0, 0, 1);
        repeat (3) cyc(1, 32'hDEAD, 32'hBEEF, 5'h1E, 2'b10, 3'b001, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
        for (int i = 1; i <= 8; i++) cyc(1, 32'(i * 4), 32'(i), 5'(i), 2'b10, 3'b000, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
        cyc(1, 32'h300, 32'h3, 5'h03, 2'b10, 3'b000, 0, 0, 1);
        cyc(1, 32'h400, 32'h4, 5'h04, 2'b10, 3'b100, 0, 0, 1);
        cyc(1, 32'h500, 32'h5, 5'h1F, 2'b11, 3'b010, 1, 1, 1);
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
        cyc(1, 32'h600, 32'h6, 5'h00, 2'b10, 3'b000, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 1600; i++) begin
            int vp, rp, fp;
            vp = (i < 400) ? 90 : (i < 800) ? 60 : (i < 1200) ? 95 : 40;
            rp = (i < 400) ? 100 : (i < 800) ? 50 : (i < 1200) ? 15 : 85;
            fp = (i < 800) ? 0 : 4;
            cyc($urandom_range(0, 99) < vp, $urandom, $urandom,
                ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                2'($urandom), 3'($urandom),
                $urandom_range(0, 99) < rp, $urandom_range(0, 99) < fp, i != 1000);
        end
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
